// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port and
// applies decode's branch redirects, parking a redirect that arrives while stalled.
//
// state   | meaning
// S_RESET | first cycle out of reset, PC not yet valid
// S_RUN   | fetching; PC advances whenever stall[0] is low
// S_HOLD  | stalled with a captured redirect waiting for release
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          IF_TO_ID_WD = 33,
    parameter int          BR_WD       = 33,
    parameter int          STALL_WD    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic                   fetch_adel,
    output logic                   redirect_pending
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        stop;
    logic [31:0] next_pc;
    logic        unused_stall_hi;

    assign br_e            = br_bus[BR_WD-1];
    assign br_addr         = br_bus[31:0];
    assign stop            = stall[0];
    assign unused_stall_hi = ^stall[STALL_WD-1:1];

    // A live redirect from decode is newer than anything parked during a stall.
    assign next_pc = br_e         ? br_addr     :
                     pend_valid_q ? pend_addr_q :
                                    pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        unique case (state_q)
            S_RESET: begin
                pc_d    = RESET_PC;
                ce_d    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stop) begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                end else if (br_e) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = br_addr;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    if (br_e) begin
                        pend_addr_d = br_addr;
                    end
                end else begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                    state_d      = S_RUN;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC - 32'd4;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    // A misaligned PC is still handed to decode so the exception travels with it.
    assign fetch_adel       = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en     = ce_q & ~fetch_adel;
    assign inst_sram_addr   = pc_q;
    assign inst_sram_wen    = 4'b0000;
    assign inst_sram_wdata  = 32'd0;
    assign if_to_id_bus     = ce_q ? {1'b1, pc_q} : '0;
    assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/branch traffic,
// checked every cycle against a simple PC/pending-target reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic [32:0] br_bus = '0;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        fetch_adel;
    logic        redirect_pending;

    int checks = 0;
    int failures = 0;

    // Reference model: the PC decode sees, whether it is valid, and a parked target.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_started;
    logic        m_pend_v;
    logic [31:0] m_pend_a;

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_bus           (br_bus),
        .if_to_id_bus     (if_to_id_bus),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_wen    (inst_sram_wen),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .fetch_adel       (fetch_adel),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC - 32'd4;
        m_ce      = 1'b0;
        m_started = 1'b0;
        m_pend_v  = 1'b0;
        m_pend_a  = 32'd0;
    endtask

    task automatic model_step(input logic stop, input logic be, input logic [31:0] ba);
        if (!m_started) begin
            m_pc      = RESET_PC;
            m_ce      = 1'b1;
            m_started = 1'b1;
        end else if (!stop) begin
            if (be)            m_pc = ba;
            else if (m_pend_v) m_pc = m_pend_a;
            else               m_pc = m_pc + 32'd4;
            m_pend_v = 1'b0;
        end else if (be) begin
            m_pend_v = 1'b1;
            m_pend_a = ba;
        end
    endtask

    task automatic check_all(input string tag);
        logic adel;
        adel = m_ce && (m_pc[1:0] != 2'b00);
        check({tag, ".bus"},  64'(if_to_id_bus), m_ce ? 64'({1'b1, m_pc}) : 64'd0);
        check({tag, ".addr"}, 64'(inst_sram_addr), 64'(m_pc));
        check({tag, ".en"},   64'(inst_sram_en), 64'(m_ce && !adel));
        check({tag, ".adel"}, 64'(fetch_adel), 64'(adel));
        check({tag, ".pend"}, 64'(redirect_pending), 64'(m_pend_v));
        check({tag, ".wen"},  64'(inst_sram_wen), 64'd0);
        check({tag, ".wdat"}, 64'(inst_sram_wdata), 64'd0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input string tag, input logic [5:0] st, input logic be, input logic [31:0] ba);
        stall  = st;
        br_bus = {be, ba};
        @(posedge clk);
        if (!rst) model_step(st[0], be, ba);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held");
        check("rst_addr", 64'(inst_sram_addr), 64'(32'hBFBF_FFFC));
        rst = 1'b0;
        #1;
        check("rel_c0_ce", 64'(if_to_id_bus[32]), 64'd0);

        cycle("rel1", 6'b0, 1'b0, 32'd0);
        check("rel_a0", 64'(inst_sram_addr), 64'(32'hBFC0_0000));
        check("rel_en", 64'(inst_sram_en), 64'd1);
        cycle("rel2", 6'b0, 1'b0, 32'd0);
        check("rel_a4", 64'(inst_sram_addr), 64'(32'hBFC0_0004));
        cycle("rel3", 6'b0, 1'b0, 32'd0);
        check("rel_a8", 64'(inst_sram_addr), 64'(32'hBFC0_0008));

        cycle("br", 6'b0, 1'b1, 32'hBFC0_0100);
        check("br_tgt", 64'(inst_sram_addr), 64'(32'hBFC0_0100));
        cycle("br_seq", 6'b0, 1'b0, 32'd0);
        check("br_next", 64'(inst_sram_addr), 64'(32'hBFC0_0104));

        cycle("to_c", 6'b0, 1'b1, 32'hBFC0_000C);
        cycle("to_10", 6'b0, 1'b0, 32'd0);
        check("st_start", 64'(inst_sram_addr), 64'(32'hBFC0_0010));
        cycle("st1", 6'b000001, 1'b0, 32'd0);
        check("st1_hold", 64'(inst_sram_addr), 64'(32'hBFC0_0010));
        cycle("st2", 6'b000001, 1'b1, 32'hBFC0_0200);
        check("st2_hold", 64'(inst_sram_addr), 64'(32'hBFC0_0010));
        check("st2_pend", 64'(redirect_pending), 64'd1);
        cycle("st3", 6'b000001, 1'b0, 32'd0);
        check("st3_pend", 64'(redirect_pending), 64'd1);
        cycle("st_rel", 6'b0, 1'b0, 32'd0);
        check("st_rel_a", 64'(inst_sram_addr), 64'(32'hBFC0_0200));
        check("st_rel_p", 64'(redirect_pending), 64'd0);

        cycle("cmp_st", 6'b000001, 1'b1, 32'hBFC0_0200);
        cycle("cmp_st2", 6'b000001, 1'b1, 32'hBFC0_0280);
        cycle("cmp_rel", 6'b0, 1'b1, 32'hBFC0_0300);
        check("cmp_live", 64'(inst_sram_addr), 64'(32'hBFC0_0300));

        cycle("mis", 6'b0, 1'b1, 32'hBFC0_0102);
        check("mis_adel", 64'(fetch_adel), 64'd1);
        check("mis_en", 64'(inst_sram_en), 64'd0);
        check("mis_bus", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0102}));
        cycle("mis2", 6'b0, 1'b0, 32'd0);
        check("mis2_a", 64'(inst_sram_addr), 64'(32'hBFC0_0106));
        check("mis2_adel", 64'(fetch_adel), 64'd1);

        cycle("wrap0", 6'b0, 1'b1, 32'hFFFF_FFFC);
        cycle("wrap1", 6'b0, 1'b0, 32'd0);
        check("wrap_a", 64'(inst_sram_addr), 64'd0);

        // stall[5:1] must have no effect
        cycle("hi_st", 6'b111110, 1'b0, 32'd0);
        check("hi_st_a", 64'(inst_sram_addr), 64'd4);

        for (int i = 0; i < 400; i++) begin
            logic [5:0]  st;
            logic        be;
            logic [31:0] ba;
            st = 6'($urandom);
            st[0] = ($urandom_range(9) < 4);
            be = ($urandom_range(9) < 3);
            ba = $urandom;
            if ($urandom_range(7) != 0) ba[1:0] = 2'b00;
            cycle("rnd", st, be, ba);
        end

        cycle("ar_pre", 6'b0, 1'b1, 32'hBFC0_0400);
        cycle("ar_st", 6'b000001, 1'b1, 32'hBFC0_0500);
        check("ar_pend", 64'(redirect_pending), 64'd1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all("ar_async");
        check("ar_bus0", 64'(if_to_id_bus), 64'd0);
        @(posedge clk);
        #1;
        check_all("ar_held");
        #2 rst = 1'b0;
        cycle("ar_rel0", 6'b000001, 1'b1, 32'hBFC0_0500);
        check("ar_restart", 64'(inst_sram_addr), 64'(RESET_PC));
        check("ar_nopend", 64'(redirect_pending), 64'd0);
        cycle("ar_rel1", 6'b0, 1'b0, 32'd0);
        check("ar_seq", 64'(inst_sram_addr), 64'(RESET_PC + 32'd4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
